vga_ball_array: RTL and testbench

Parametrised multi-ball demo generator for the DVI/VGA video path. Animates NUM_BALLS independent square sprites inside a configurable active area, composites them by fixed priority over a black background, and re-aligns the incoming sync/active strobes to the pixel output. It sits between the `vga_timing` generator and the DVI encoder, replacing the single-ball demo path when multiple sprites are wanted.

---
 rtl/vga_ball_array.sv | 164 ++++++++++++++++
 tb/tb_vga_ball_array.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_ball_array.sv
// vga_ball_array: NUM_BALLS bouncing square sprites composited over black with a 2-cycle pixel pipeline.
// Optional feature macro VGA_BALL_RECOLOR_EN: a ball takes a new colour from random_num on frames where it bounces.
module vga_ball_array #(
  parameter int NUM_BALLS = 4,
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 600,
  parameter int BALL_SIZE = 16,
  parameter int MARGIN    = 32
) (
  input  logic        clk_dot,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] random_num,
  input  logic        vid_new_frame,
  input  logic        vid_new_line,
  input  logic        vid_active_in,
  input  logic        vga_hsync_in,
  input  logic        vga_vsync_in,
  output logic [23:0] vga_pixel_rgb,
  output logic        vga_active,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [15:0] bounce_cnt
);

  localparam logic [15:0]        X_LO   = 16'(MARGIN);
  localparam logic [15:0]        X_HI   = 16'(H_ACTIVE - MARGIN);
  localparam logic [15:0]        Y_LO   = 16'(MARGIN);
  localparam logic [15:0]        Y_HI   = 16'(V_ACTIVE - MARGIN);
  localparam logic [23:0]        X_SEED = {16'(H_ACTIVE / 2), 8'h00};
  localparam logic [23:0]        Y_SEED = {16'(V_ACTIVE / 2), 8'h00};
  localparam logic signed [16:0] HALF_S = 17'(BALL_SIZE / 2);

  function automatic logic [23:0] rot24(input logic [31:0] v, input int n);
    return 24'(({v, v} >> n));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic near(input logic [15:0] pel, input logic [15:0] pos);
    logic signed [16:0] d;
    d = $signed({1'b0, pel}) - $signed({1'b0, pos});
    if (d[16]) d = -d;
    return d < HALF_S;
  endfunction

  logic [23:0] x_q  [NUM_BALLS];
  logic [23:0] x_d  [NUM_BALLS];
  logic [23:0] y_q  [NUM_BALLS];
  logic [23:0] y_d  [NUM_BALLS];
  logic [11:0] dx_q [NUM_BALLS];
  logic [11:0] dx_d [NUM_BALLS];
  logic [11:0] dy_q [NUM_BALLS];
  logic [11:0] dy_d [NUM_BALLS];
  logic [23:0] c_q  [NUM_BALLS];
  logic [23:0] c_d  [NUM_BALLS];
  logic [23:0] rot_w [NUM_BALLS];
  logic [NUM_BALLS-1:0] flip_x, flip_y;
  logic        any_flip;

  logic [15:0] pel_x_q, pel_x_d, pel_y_q, pel_y_d;
  logic [15:0] bounce_q, bounce_d;
  logic        act_p1, hs_p1, vs_p1;
  logic        act_p2, hs_p2, vs_p2;
  logic [23:0] mux_w, rgb_d, rgb_q;

  // Flips are judged on the pre-update integer position and only when heading into the wall.
  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    assign rot_w[g]  = rot24(random_num, 4 * g);
    assign flip_x[g] = (x_q[g][23:8] < X_LO && dx_q[g][11]) || (x_q[g][23:8] > X_HI && !dx_q[g][11]);
    assign flip_y[g] = (y_q[g][23:8] < Y_LO && dy_q[g][11]) || (y_q[g][23:8] > Y_HI && !dy_q[g][11]);
  end
  assign any_flip = |(flip_x | flip_y);

  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      dx_d[i] = dx_q[i];
      dy_d[i] = dy_q[i];
      c_d[i]  = c_q[i];
      if (reset || !enable) begin
        x_d[i]  = X_SEED;
        y_d[i]  = Y_SEED;
        dx_d[i] = {2'b01, rot_w[i][11:2]};
        dy_d[i] = {2'b01, rot_w[i][23:14]};
        c_d[i]  = {1'b1, rot_w[i][22:0]};
      end else if (vid_new_frame) begin
        x_d[i] = x_q[i] + {{12{dx_q[i][11]}}, dx_q[i]};
        y_d[i] = y_q[i] + {{12{dy_q[i][11]}}, dy_q[i]};
        if (flip_x[i]) dx_d[i] = 12'd0 - dx_q[i];
        if (flip_y[i]) dy_d[i] = 12'd0 - dy_q[i];
`ifdef VGA_BALL_RECOLOR_EN
        if (flip_x[i] || flip_y[i]) c_d[i] = {1'b1, rot_w[i][22:0]};
`endif
      end
    end
  end

  always_comb begin
    bounce_d = bounce_q;
    if (enable && vid_new_frame && any_flip) bounce_d = sat_inc(bounce_q);
  end

  always_comb begin
    pel_x_d = vid_new_line ? 16'd0 : sat_inc(pel_x_q);
    pel_y_d = pel_y_q;
    if (vid_new_frame)     pel_y_d = 16'd0;
    else if (vid_new_line) pel_y_d = sat_inc(pel_y_q);
  end

  // Reverse scan so the lowest-index hit is the last to write.
  always_comb begin
    mux_w = 24'h000000;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (near(pel_x_q, x_q[i][23:8]) && near(pel_y_q, y_q[i][23:8])) mux_w = c_q[i];
    end
    rgb_d = (act_p1 && enable) ? mux_w : 24'h000000;
  end

  always_ff @(posedge clk_dot) begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      x_q[i]  <= x_d[i];
      y_q[i]  <= y_d[i];
      dx_q[i] <= dx_d[i];
      dy_q[i] <= dy_d[i];
      c_q[i]  <= c_d[i];
    end
    if (reset) begin
      pel_x_q  <= '0;
      pel_y_q  <= '0;
      act_p1   <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      rgb_q    <= '0;
      act_p2   <= 1'b0;
      hs_p2    <= 1'b0;
      vs_p2    <= 1'b0;
      bounce_q <= '0;
    end else begin
      // stage 1: raster position and raw timing
      pel_x_q  <= pel_x_d;
      pel_y_q  <= pel_y_d;
      act_p1   <= vid_active_in;
      hs_p1    <= vga_hsync_in;
      vs_p1    <= vga_vsync_in;
      // stage 2: composited pixel and aligned timing
      rgb_q    <= rgb_d;
      act_p2   <= act_p1;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
      bounce_q <= bounce_d;
    end
  end

  assign vga_pixel_rgb = rgb_q;
  assign vga_active    = act_p2;
  assign vga_hsync     = hs_p2;
  assign vga_vsync     = vs_p2;
  assign bounce_cnt    = bounce_q;

endmodule

// File: tb/tb_vga_ball_array.sv
// Randomized bench for vga_ball_array on a reduced raster, checked every cycle against a frame-level ball model.
module tb_vga_ball_array;

  localparam int NB = 4, HA = 48, VA = 40, BS = 6, MG = 16;
  localparam int HT = 52, VT = 42, FT = HT * VT;

  logic        clk_dot = 1'b0;
  logic        reset, enable, vid_new_frame, vid_new_line;
  logic        vid_active_in, vga_hsync_in, vga_vsync_in;
  logic [31:0] random_num;
  logic [23:0] vga_pixel_rgb;
  logic        vga_active, vga_hsync, vga_vsync;
  logic [15:0] bounce_cnt;

  always #5 clk_dot = ~clk_dot;

  vga_ball_array #(
    .NUM_BALLS(NB), .H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS), .MARGIN(MG)
  ) dut (
    .clk_dot(clk_dot), .reset(reset), .enable(enable), .random_num(random_num),
    .vid_new_frame(vid_new_frame), .vid_new_line(vid_new_line),
    .vid_active_in(vid_active_in), .vga_hsync_in(vga_hsync_in), .vga_vsync_in(vga_vsync_in),
    .vga_pixel_rgb(vga_pixel_rgb), .vga_active(vga_active), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .bounce_cnt(bounce_cnt)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: positions in 1/256 px, velocities as signed integers.
  int          bx [NB], by [NB], bdx [NB], bdy [NB];
  logic [23:0] bc [NB];
  int          m_px, m_py, e_bcnt;
  bit          m_act1, m_hs1, m_vs1, e_act, e_hs, e_vs;
  logic [23:0] e_rgb;

  function automatic logic [31:0] rot(input logic [31:0] v, input int i);
    return (v >> (4 * i)) | (v << (32 - 4 * i));
  endfunction

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic logic [23:0] pixel_at(input int px, input int py);
    int cx, cy;
    for (int i = 0; i < NB; i++) begin
      cx = bx[i] / 256;
      cy = by[i] / 256;
      if (iabs(px - cx) < BS / 2 && iabs(py - cy) < BS / 2) return bc[i];
    end
    return 24'h000000;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input bit nf, input bit nl,
                            input bit act, input bit hs, input bit vs, input logic [31:0] rn);
    logic [31:0] r;
    bit fx, fy, any;
    if (rst) begin
      e_rgb = 24'h0; e_act = 0; e_hs = 0; e_vs = 0;
    end else begin
      e_rgb = (m_act1 && en) ? pixel_at(m_px, m_py) : 24'h0;
      e_act = m_act1; e_hs = m_hs1; e_vs = m_vs1;
    end
    if (rst) begin
      m_act1 = 0; m_hs1 = 0; m_vs1 = 0; m_px = 0; m_py = 0;
    end else begin
      m_act1 = act; m_hs1 = hs; m_vs1 = vs;
      if (nf)      m_py = 0;
      else if (nl) m_py = (m_py < 65535) ? m_py + 1 : 65535;
      m_px = nl ? 0 : ((m_px < 65535) ? m_px + 1 : 65535);
    end
    any = 0;
    for (int i = 0; i < NB; i++) begin
      r = rot(rn, i);
      if (rst || !en) begin
        bx[i]  = (HA / 2) * 256;
        by[i]  = (VA / 2) * 256;
        bdx[i] = 1024 + int'((r >> 2) & 32'h3FF);
        bdy[i] = 1024 + int'((r >> 14) & 32'h3FF);
        bc[i]  = 24'h800000 | r[22:0];
      end else if (nf) begin
        fx = ((bx[i] / 256) < MG && bdx[i] < 0) || ((bx[i] / 256) > HA - MG && bdx[i] >= 0);
        fy = ((by[i] / 256) < MG && bdy[i] < 0) || ((by[i] / 256) > VA - MG && bdy[i] >= 0);
        bx[i] = (bx[i] + bdx[i] + 16777216) % 16777216;
        by[i] = (by[i] + bdy[i] + 16777216) % 16777216;
        if (fx) bdx[i] = -bdx[i];
        if (fy) bdy[i] = -bdy[i];
`ifdef VGA_BALL_RECOLOR_EN
        if (fx || fy) bc[i] = 24'h800000 | r[22:0];
`endif
        any = any | fx | fy;
      end
    end
    if (rst) e_bcnt = 0;
    else if (en && nf && any && e_bcnt < 65535) e_bcnt++;
  endtask

  int          h, v, hprev = -1, vprev = -1;
  bit          rst_v, en_v, chk_dir;
  logic [31:0] rn_v;

  task automatic step();
    bit nf, nl, act, hs, vs;
    nl  = (h == 0);
    nf  = (h == 0 && v == 0);
    act = (h < HA && v < VA);
    hs  = 1'($urandom & 1);
    vs  = 1'($urandom & 1);
    reset = rst_v; enable = en_v; random_num = rn_v;
    vid_new_frame = nf; vid_new_line = nl; vid_active_in = act;
    vga_hsync_in = hs; vga_vsync_in = vs;
    @(posedge clk_dot);
    model_edge(rst_v, en_v, nf, nl, act, hs, vs, rn_v);
    #1;
    check("rgb", 32'(vga_pixel_rgb), 32'(e_rgb));
    check("active", 32'(vga_active), 32'(e_act));
    check("hsync", 32'(vga_hsync), 32'(e_hs));
    check("vsync", 32'(vga_vsync), 32'(e_vs));
    check("bounce_cnt", 32'(bounce_cnt), 32'(e_bcnt));
    // First frame after release with random_num=0: every ball sits at (28,24) in colour 0x800000.
    if (chk_dir && vprev == 24) begin
      if (hprev == 28 || hprev == 30) check("ball0_inside", 32'(vga_pixel_rgb), 32'h800000);
      if (hprev == 31) check("ball0_right_edge", 32'(vga_pixel_rgb), 32'h0);
    end
    if (chk_dir && vprev == 27 && hprev == 28) check("ball0_below", 32'(vga_pixel_rgb), 32'h0);
    hprev = h;
    vprev = v;
    h++;
    if (h == HT) begin
      h = 0;
      v = (v == VT - 1) ? 0 : v + 1;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; random_num = '0; vid_new_frame = 1'b0; vid_new_line = 1'b0;
    vid_active_in = 1'b0; vga_hsync_in = 1'b0; vga_vsync_in = 1'b0;
    rst_v = 1; en_v = 1; rn_v = 32'h0; h = 0; v = 0; chk_dir = 0;
    run(4);
    h = 0; v = 0; rst_v = 0; chk_dir = 1;
    run(FT);
    chk_dir = 0;
    run(4 * FT);
    // Five frame steps from centre at +4 px: Y flips on the third, X on the fourth.
    check("bounce_after_5_frames", 32'(bounce_cnt), 32'd2);
    rn_v = $urandom; en_v = 0;
    run(10);
    en_v = 1;
    for (int f = 0; f < 6; f++) begin
      rn_v = $urandom;
      run(FT);
    end
    run(777);
    en_v = 0;
    run(300);
    rn_v = $urandom;
    run(30);
    en_v = 1;
    run(2 * FT);
    for (int f = 0; f < 8; f++) begin
      run(FT / 2);
      rn_v = $urandom;
      run(FT - FT / 2);
    end
    run(500);
    rst_v = 1;
    run(2);
    rst_v = 0;
    run(2 * FT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
